// File: rtl/an_encoder_28bits_if.sv
// Handshake bundle between the AN-code encoder and its neighbours.
// The master modport is the upstream/downstream side; slave is the encoder.
interface an_encoder_28bits_if #(
    parameter int unsigned N_BITS = 28,
    parameter int unsigned W_BITS = 44,
    parameter int unsigned P_BITS = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] N_in;
    logic              inj1_en;
    logic [P_BITS-1:0] inj1_pos;
    logic              inj1_neg;
    logic              inj2_en;
    logic [P_BITS-1:0] inj2_pos;
    logic              inj2_neg;
    logic              out_valid;
    logic              out_ready;
    logic [W_BITS-1:0] W_out;
    logic              out_wrap;

    modport master (
        output in_valid, N_in, inj1_en, inj1_pos, inj1_neg,
               inj2_en, inj2_pos, inj2_neg, out_ready,
        input  in_ready, out_valid, W_out, out_wrap
    );

    modport slave (
        input  in_valid, N_in, inj1_en, inj1_pos, inj1_neg,
               inj2_en, inj2_pos, inj2_neg, out_ready,
        output in_ready, out_valid, W_out, out_wrap
    );
endinterface

// File: rtl/an_encoder_28bits.sv
// AN-code encoder: W = A*N by one-bit-per-cycle shift-and-add, then optional
// injection of up to two +/-2^p arithmetic errors for decoder stimulation.
module an_encoder_28bits #(
    parameter int unsigned A      = 17619,
    parameter int unsigned A_BITS = 15,
    parameter int unsigned N_BITS = 28,
    parameter int unsigned W_BITS = N_BITS + A_BITS + 1,
    parameter int unsigned P_BITS = 6
) (
    input logic               clk,
    input logic               rst_n,
    an_encoder_28bits_if.slave bus
);
    localparam int unsigned C_BITS = $clog2(N_BITS);
    localparam int unsigned S_BITS = W_BITS + 2;

    typedef enum logic [1:0] {IDLE, MUL, INJ, OUT} state_e;

    state_e              state_q, state_d;
    logic [W_BITS-1:0]   acc_q, acc_d;
    logic [N_BITS-1:0]   shift_q, shift_d;
    logic [C_BITS-1:0]   cnt_q, cnt_d;
    logic                inj1_en_q, inj1_en_d, inj1_neg_q, inj1_neg_d;
    logic                inj2_en_q, inj2_en_d, inj2_neg_q, inj2_neg_d;
    logic [P_BITS-1:0]   inj1_pos_q, inj1_pos_d, inj2_pos_q, inj2_pos_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [W_BITS-1:0]   w_out_q, w_out_d;
    logic                out_wrap_q, out_wrap_d;

    logic signed [S_BITS-1:0] err1_c, err2_c, sum_c;

    // Signed error terms; positions beyond the codeword are dropped.
    always_comb begin
        err1_c = '0;
        err2_c = '0;
        if (inj1_en_q && (inj1_pos_q < P_BITS'(W_BITS))) begin
            err1_c = S_BITS'(1) << inj1_pos_q;
            if (inj1_neg_q) err1_c = -err1_c;
        end
        if (inj2_en_q && (inj2_pos_q < P_BITS'(W_BITS))) begin
            err2_c = S_BITS'(1) << inj2_pos_q;
            if (inj2_neg_q) err2_c = -err2_c;
        end
        sum_c = $signed({2'b00, acc_q}) + err1_c + err2_c;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        inj1_en_d   = inj1_en_q;
        inj1_pos_d  = inj1_pos_q;
        inj1_neg_d  = inj1_neg_q;
        inj2_en_d   = inj2_en_q;
        inj2_pos_d  = inj2_pos_q;
        inj2_neg_d  = inj2_neg_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        w_out_d     = w_out_q;
        out_wrap_d  = out_wrap_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    shift_d    = bus.N_in;
                    inj1_en_d  = bus.inj1_en;
                    inj1_pos_d = bus.inj1_pos;
                    inj1_neg_d = bus.inj1_neg;
                    inj2_en_d  = bus.inj2_en;
                    inj2_pos_d = bus.inj2_pos;
                    inj2_neg_d = bus.inj2_neg;
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = MUL;
                end
            end
            MUL: begin
                if (shift_q[0]) acc_d = acc_q + (W_BITS'(A) << cnt_q);
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + C_BITS'(1);
                if (cnt_q == C_BITS'(N_BITS - 1)) state_d = INJ;
            end
            INJ: begin
                w_out_d     = sum_c[W_BITS-1:0];
                out_wrap_d  = sum_c[S_BITS-1] | sum_c[W_BITS];
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            inj1_en_q   <= 1'b0;
            inj1_pos_q  <= '0;
            inj1_neg_q  <= 1'b0;
            inj2_en_q   <= 1'b0;
            inj2_pos_q  <= '0;
            inj2_neg_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            w_out_q     <= '0;
            out_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            inj1_en_q   <= inj1_en_d;
            inj1_pos_q  <= inj1_pos_d;
            inj1_neg_q  <= inj1_neg_d;
            inj2_en_q   <= inj2_en_d;
            inj2_pos_q  <= inj2_pos_d;
            inj2_neg_q  <= inj2_neg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            w_out_q     <= w_out_d;
            out_wrap_q  <= out_wrap_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.W_out     = w_out_q;
    assign bus.out_wrap  = out_wrap_q;
endmodule
